// File: rtl/alu_mdu_control.sv
// Execute-stage ALU opcode decode plus an iterative radix-2 RV32M multiply/divide sequencer.
// A single accumulator is shared by shift-add multiply and restoring divide; stall_o holds the pipe until done.
module alu_mdu_control #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [6:0]        funct7_i,
    input  logic [2:0]        ALU_Op_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    output logic [3:0]        ALU_Operation_o,
    output logic [XLEN-1:0]   mdu_result_o,
    output logic              stall_o,
    output logic              done_o
);
    localparam int CW = $clog2(XLEN + 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_LUI  = 4'b1010;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic                rneg_q, rneg_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                m_op;
    logic                a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]     a_mag, b_mag, special_res, final_res;
    logic [XLEN:0]       mul_sum, rem_sh, diff;
    logic                ge;
    logic [2*XLEN-1:0]   step, prod_s;

    assign m_op = (ALU_Op_i == 3'b000) && (funct7_i == 7'b0000001);

    function automatic logic [3:0] base_op(input logic [2:0] f3);
        case (f3)
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return OP_SRL;
            3'b110:  return OP_OR;
            3'b111:  return OP_AND;
            default: return OP_ADD;
        endcase
    endfunction

    always_comb begin
        ALU_Operation_o = OP_ADD;
        case (ALU_Op_i)
            3'b000: begin
                if (funct7_i == 7'b0000000) begin
                    ALU_Operation_o = base_op(funct3_i);
                end else if (funct7_i == 7'b0100000) begin
                    if (funct3_i == 3'b000)      ALU_Operation_o = OP_SUB;
                    else if (funct3_i == 3'b101) ALU_Operation_o = OP_SRA;
                end
            end
            3'b001: begin
                if (funct3_i == 3'b101) ALU_Operation_o = funct7_i[5] ? OP_SRA : OP_SRL;
                else                    ALU_Operation_o = base_op(funct3_i);
            end
            3'b010:  ALU_Operation_o = OP_LUI;
            default: ALU_Operation_o = OP_ADD;
        endcase
    end

    // Operand conditioning at issue: magnitudes plus the signs needed to fix up the result.
    always_comb begin
        a_neg    = (funct3_i inside {3'b001, 3'b010, 3'b100, 3'b110}) && rs1_data_i[XLEN-1];
        b_neg    = (funct3_i inside {3'b001, 3'b100, 3'b110}) && rs2_data_i[XLEN-1];
        a_mag    = a_neg ? -rs1_data_i : rs1_data_i;
        b_mag    = b_neg ? -rs2_data_i : rs2_data_i;
        div_zero = funct3_i[2] && (rs2_data_i == '0);
        div_ovf  = funct3_i[2] && !funct3_i[0]
                   && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}})
                   && (rs2_data_i == '1);
        if (funct3_i[1]) special_res = div_zero ? rs1_data_i : '0;
        else             special_res = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // One iteration: low half holds multiplier/dividend bits, high half the partial sum/remainder.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff    = rem_sh - {1'b0, opb_q};
        ge      = !diff[XLEN];
        if (op_q[2])
            step = {(ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], ge};
        else
            step = {mul_sum, acc_q[XLEN-1:1]};
        prod_s = neg_q ? -step : step;
        case (op_q)
            3'b000:          final_res = prod_s[XLEN-1:0];
            3'b100, 3'b101:  final_res = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
            3'b110, 3'b111:  final_res = rneg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
            default:         final_res = prod_s[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (valid_i && m_op) begin
                    op_d    = funct3_i;
                    count_d = '0;
                    acc_d   = {{XLEN{1'b0}}, a_mag};
                    opb_d   = b_mag;
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else begin
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                acc_d   = step;
                count_d = count_q + 1'b1;
                if (count_q == CW'(XLEN - 1)) begin
                    result_d = final_res;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign stall_o      = !reset && (((state_q == IDLE) && valid_i && m_op) || (state_q == BUSY));
    assign done_o       = (state_q == DONE);
    assign mdu_result_o = result_q;

endmodule

// File: tb/tb_alu_mdu_control.sv
// Randomized self-checking bench for alu_mdu_control; results are compared with plain 64-bit arithmetic.
module tb_alu_mdu_control;
    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic [6:0]  funct7_i;
    logic [2:0]  ALU_Op_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_data_i, rs2_data_i;
    logic [3:0]  ALU_Operation_o;
    logic [31:0] mdu_result_o;
    logic        stall_o, done_o;

    int n_cmp = 0;
    int n_err = 0;

    alu_mdu_control #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .funct7_i(funct7_i),
        .ALU_Op_i(ALU_Op_i), .funct3_i(funct3_i), .rs1_data_i(rs1_data_i),
        .rs2_data_i(rs2_data_i), .ALU_Operation_o(ALU_Operation_o),
        .mdu_result_o(mdu_result_o), .stall_o(stall_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] base_ref(input logic [2:0] f3);
        case (f3)
            3'd0: return 4'b0000;
            3'd1: return 4'b0010;
            3'd2: return 4'b0011;
            3'd3: return 4'b0100;
            3'd4: return 4'b0101;
            3'd5: return 4'b0110;
            3'd6: return 4'b1001;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [3:0] dec_ref(input logic [2:0] aop, input logic [2:0] f3, input logic [6:0] f7);
        if (aop == 3'b010) return 4'b1010;
        if (aop == 3'b001) begin
            if (f3 == 3'd5) return f7[5] ? 4'b0111 : 4'b0110;
            return base_ref(f3);
        end
        if (aop == 3'b000) begin
            if (f7 == 7'h00) return base_ref(f3);
            if (f7 == 7'h20 && f3 == 3'd0) return 4'b0001;
            if (f7 == 7'h20 && f3 == 3'd5) return 4'b0111;
        end
        return 4'b0000;
    endfunction

    function automatic logic [31:0] mdu_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issues one M-op in the cycle after the current one and follows it to done_o.
    task automatic run_mop(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int exp_lat, lat;
        logic seen, stall_bad;
        exp     = mdu_ref(f3, a, b);
        exp_lat = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
        tick();
        valid_i = 1'b1; ALU_Op_i = 3'b000; funct7_i = 7'b0000001;
        funct3_i = f3; rs1_data_i = a; rs2_data_i = b;
        #1;
        check({tag, "_stall_issue"}, stall_o, 1);
        check({tag, "_aluop"}, ALU_Operation_o, 0);
        lat = 0; seen = 1'b0; stall_bad = 1'b0;
        while (!seen && lat < 40) begin
            tick();
            lat++;
            valid_i = 1'b0;
            rs1_data_i = $urandom; rs2_data_i = $urandom; funct3_i = 3'($urandom);
            #1;
            if (done_o) seen = 1'b1;
            else if (!stall_o) stall_bad = 1'b1;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_stall_busy"}, stall_bad, 0);
        check({tag, "_result"}, mdu_result_o, exp);
        check({tag, "_stall_done"}, stall_o, 0);
    endtask

    initial begin
        int lat;
        logic seen;
        reset = 1'b1; valid_i = 1'b1; ALU_Op_i = 3'b000; funct7_i = 7'b0000001;
        funct3_i = 3'd0; rs1_data_i = 32'd3; rs2_data_i = 32'd4;
        tick(); tick();
        check("rst_stall", stall_o, 0);
        check("rst_done", done_o, 0);
        check("rst_result", mdu_result_o, 0);
        reset = 1'b0; valid_i = 1'b0;
        #1;

        // Directed decode cases
        valid_i = 1'b1;
        ALU_Op_i = 3'b001; funct3_i = 3'b110; funct7_i = 7'h00; #1;
        check("dec_ori", ALU_Operation_o, 4'b1001); check("dec_ori_stall", stall_o, 0);
        ALU_Op_i = 3'b000; funct3_i = 3'b000; funct7_i = 7'h20; #1;
        check("dec_sub", ALU_Operation_o, 4'b0001);
        ALU_Op_i = 3'b001; funct3_i = 3'b101; funct7_i = 7'h20; #1;
        check("dec_srai", ALU_Operation_o, 4'b0111);
        ALU_Op_i = 3'b010; funct3_i = 3'b011; #1;
        check("dec_lui", ALU_Operation_o, 4'b1010);
        ALU_Op_i = 3'b011; #1;
        check("dec_other", ALU_Operation_o, 4'b0000); check("dec_other_stall", stall_o, 0);

        // Random decode sweep
        for (int i = 0; i < 40; i++) begin
            ALU_Op_i = 3'($urandom_range(0, 4));
            funct3_i = 3'($urandom);
            case ($urandom_range(0, 2))
                0: funct7_i = 7'h00;
                1: funct7_i = 7'h20;
                default: funct7_i = 7'($urandom);
            endcase
            valid_i = !(ALU_Op_i == 3'b000 && funct7_i == 7'h01);
            #1;
            check("dec_rand", ALU_Operation_o, dec_ref(ALU_Op_i, funct3_i, funct7_i));
            check("dec_rand_stall", stall_o, 0);
        end
        valid_i = 1'b0;

        // Directed M-ops
        run_mop("mul",     3'd0, 32'd7, 32'hFFFF_FFFD);
        run_mop("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_mop("mulh",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_mop("div",     3'd4, 32'hFFFF_FFF9, 32'd2);
        run_mop("rem",     3'd6, 32'hFFFF_FFF9, 32'd2);
        run_mop("divu",    3'd5, 32'hFFFF_FFF9, 32'd2);
        run_mop("divu_z",  3'd5, 32'd5, 32'd0);
        run_mop("rem_z",   3'd6, 32'd5, 32'd0);
        run_mop("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_mop("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_mop("b2b_mul", 3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        run_mop("b2b_remu", 3'd7, 32'd10, 32'd3);

        // Reset during BUSY aborts the op silently
        tick();
        valid_i = 1'b1; ALU_Op_i = 3'b000; funct7_i = 7'h01; funct3_i = 3'd0;
        rs1_data_i = 32'd11; rs2_data_i = 32'd13;
        for (int c = 1; c <= 10; c++) begin
            tick();
            valid_i = 1'b0; rs1_data_i = $urandom; rs2_data_i = $urandom;
        end
        reset = 1'b1; #1;
        check("rst_mid_stall_now", stall_o, 0);
        tick();
        reset = 1'b0; #1;
        check("rst_mid_stall_after", stall_o, 0);
        check("rst_mid_done_after", done_o, 0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done_o || stall_o) seen = 1'b1;
        end
        check("rst_mid_no_done", seen, 0);
        run_mop("divu_after_rst", 3'd5, 32'd9, 32'd3);

        // Random M-ops, occasionally steered into the special divide cases
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_mop("rand", 3'($urandom), a, b);
        end

        lat = 0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
